// File: rtl/regfile_debug_port.sv
// Debug/host initiator that reads and writes architectural registers through
// the register file's ACC-staged strobe protocol while the core grants the buses.
module regfile_debug_port #(
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned REG_ADDR_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [REG_ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_W-1:0]         req_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_error,
   output logic                      bus_req,
   input  logic                      bus_grant,
   output logic [REG_ADDR_WIDTH-1:0] rf_reg_addr,
   output logic [DATA_W-1:0]         rf_acc_in,
   output logic                      rf_acc_in_oe,
   output logic                      rf_acc_write_enable,
   output logic                      rf_write_put_acc,
   output logic                      rf_read_data_output_enable,
   input  logic [DATA_W-1:0]         rf_read_data,
   input  logic [DATA_W-1:0]         rf_acc_out,
   output logic                      rf_status_write_enable,
   output logic                      rf_zero_flag,
   output logic                      rf_positive_flag,
   output logic                      rf_carry_flag,
   output logic                      rf_overflow_flag
);

   localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ACC    = REG_ADDR_WIDTH'(8);
   localparam logic [REG_ADDR_WIDTH-1:0] ADDR_STATUS = REG_ADDR_WIDTH'(13);

   localparam int unsigned ZERO_FLAG     = 0;
   localparam int unsigned POSITIVE_FLAG = 1;
   localparam int unsigned CARRY_FLAG    = 2;
   localparam int unsigned OVERFLOW_FLAG = 3;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PUT,
      RESTORE,
      STAT,
      READ,
      RESP
   } state_t;

   state_t                      state, next_state;
   logic                        wr_q;
   logic [REG_ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_W-1:0]           wdata_q;
   logic [DATA_W-1:0]           acc_save;
   logic [DATA_W-1:0]           rdata_q;
   logic                        error_q;
   logic                        accept;
   logic                        addr_invalid;

   assign accept       = (state == IDLE) && req_valid && bus_grant;
   assign addr_invalid = req_addr > ADDR_STATUS;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         acc_save <= '0;
         rdata_q  <= '0;
         error_q  <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            wr_q     <= req_write;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            acc_save <= rf_acc_out;
            rdata_q  <= '0;
            error_q  <= addr_invalid;
         end
         if ((state == READ) && bus_grant) begin
            rdata_q <= rf_read_data;
         end
      end
   end

   // Op states only advance while granted; losing grant freezes the sequence.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (addr_invalid)             next_state = RESP;
               else if (!req_write)          next_state = READ;
               else if (req_addr == ADDR_STATUS) next_state = STAT;
               else                          next_state = LOAD;
            end
         end
         LOAD: begin
            if (bus_grant) next_state = (addr_q == ADDR_ACC) ? RESP : PUT;
         end
         PUT: begin
            if (bus_grant) next_state = RESTORE;
         end
         RESTORE, STAT, READ: begin
            if (bus_grant) next_state = RESP;
         end
         RESP: begin
            if (rsp_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      req_ready                  = (state == IDLE) && bus_grant;
      bus_req                    = ((state == IDLE) && req_valid) ||
                                   ((state != IDLE) && (state != RESP));
      rsp_valid                  = (state == RESP);
      rsp_rdata                  = rdata_q;
      rsp_error                  = error_q;
      rf_reg_addr                = '0;
      rf_acc_in                  = '0;
      rf_acc_in_oe               = 1'b0;
      rf_acc_write_enable        = 1'b0;
      rf_write_put_acc           = 1'b0;
      rf_read_data_output_enable = 1'b0;
      rf_status_write_enable     = 1'b0;
      rf_zero_flag               = 1'b0;
      rf_positive_flag           = 1'b0;
      rf_carry_flag              = 1'b0;
      rf_overflow_flag           = 1'b0;
      if (bus_grant) begin
         case (state)
            LOAD: begin
               rf_acc_in           = wdata_q;
               rf_acc_in_oe        = 1'b1;
               rf_acc_write_enable = 1'b1;
            end
            PUT: begin
               rf_reg_addr      = addr_q;
               rf_write_put_acc = 1'b1;
            end
            RESTORE: begin
               rf_acc_in           = acc_save;
               rf_acc_in_oe        = 1'b1;
               rf_acc_write_enable = 1'b1;
            end
            STAT: begin
               rf_status_write_enable = 1'b1;
               rf_zero_flag           = wdata_q[ZERO_FLAG];
               rf_positive_flag       = wdata_q[POSITIVE_FLAG];
               rf_carry_flag          = wdata_q[CARRY_FLAG];
               rf_overflow_flag       = wdata_q[OVERFLOW_FLAG];
            end
            READ: begin
               rf_reg_addr                = addr_q;
               rf_read_data_output_enable = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // wr_q is latched for completeness of the request record; routing is decided at accept.
   logic unused_ok;
   assign unused_ok = wr_q;

endmodule
